// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL lock supervisor: state encoding,
// default timing constants and the counter-width helper.
package pll_sup_pkg;

   localparam int unsigned STABLE_CYCLES_DEF = 1024;
   localparam int unsigned HOLD_CYCLES_DEF   = 16;
   localparam int unsigned LOSS_FILTER_DEF   = 4;
   localparam int unsigned LOSS_COUNT_W      = 8;

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      STABILIZE = 3'd1,
      HOLD      = 3'd2,
      RUN       = 3'd3,
      LOST      = 3'd4
   } sup_state_e;

   // A parameter of 1 still needs a 1-bit counter to hold the value 0.
   function automatic int unsigned cnt_width(input int unsigned n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Lock/status bundle between the PLL supervisor (slave) and whatever
// drives the raw lock and consumes the reset/status outputs (master).
interface pll_lock_supervisor_if;
   import pll_sup_pkg::*;

   logic                    locked;
   logic                    clear_lost;
   logic                    sys_rst_n;
   logic                    ready;
   logic                    lost;
   logic [LOSS_COUNT_W-1:0] loss_count;

   modport master (
      output locked, clear_lost,
      input  sys_rst_n, ready, lost, loss_count
   );

   modport slave (
      input  locked, clear_lost,
      output sys_rst_n, ready, lost, loss_count
   );

endinterface

// File: rtl/sync_2ff.sv
// Reusable two-flop synchronizer for bringing asynchronous levels into clk.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Holds downstream logic in reset until the PLL lock is stable, then watches
// for lock loss. Define PLL_SUP_LOSS_COUNT_EN to build the loss event counter.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
   parameter int unsigned LOSS_FILTER   = LOSS_FILTER_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pll_lock_supervisor_if.slave  bus
);

   localparam int unsigned SW = cnt_width(STABLE_CYCLES);
   localparam int unsigned HW = cnt_width(HOLD_CYCLES);
   localparam int unsigned LW = cnt_width(LOSS_FILTER);

   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_FILTER - 1);

   logic          locked_s;
   sup_state_e    state_q, state_d;
   logic [SW-1:0] stab_cnt_q, stab_cnt_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [LW-1:0] loss_cnt_q, loss_cnt_d;
   logic          sys_rst_n_q, sys_rst_n_d;
   logic          ready_q, ready_d;
   logic          lost_q, lost_d;
   logic          loss_entry;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.locked),
      .q     (locked_s)
   );

   always_comb begin
      state_d    = state_q;
      stab_cnt_d = stab_cnt_q;
      hold_cnt_d = hold_cnt_q;
      loss_cnt_d = '0;
      case (state_q)
         WAIT_LOCK: begin
            if (locked_s) begin
               state_d    = STABILIZE;
               stab_cnt_d = '0;
            end
         end
         STABILIZE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (stab_cnt_q == STAB_LAST) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end else begin
               stab_cnt_d = stab_cnt_q + 1'b1;
            end
         end
         HOLD, RUN: begin
            // Loss filter is evaluated first so a loss beats HOLD->RUN.
            if (!locked_s) begin
               if (loss_cnt_q == LOSS_LAST) state_d = LOST;
               else                         loss_cnt_d = loss_cnt_q + 1'b1;
            end
            if (state_q == HOLD && state_d != LOST) begin
               if (hold_cnt_q == HOLD_LAST) state_d = RUN;
               else                         hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         LOST:    state_d = WAIT_LOCK;
         default: state_d = WAIT_LOCK;
      endcase

      loss_entry  = (state_d == LOST);
      sys_rst_n_d = (state_d == RUN);
      ready_d     = (state_d == RUN);
      if (loss_entry)          lost_d = 1'b1;
      else if (bus.clear_lost) lost_d = 1'b0;
      else                     lost_d = lost_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= WAIT_LOCK;
         stab_cnt_q  <= '0;
         hold_cnt_q  <= '0;
         loss_cnt_q  <= '0;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         lost_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         stab_cnt_q  <= stab_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         loss_cnt_q  <= loss_cnt_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         lost_q      <= lost_d;
      end
   end

   assign bus.sys_rst_n = sys_rst_n_q;
   assign bus.ready     = ready_q;
   assign bus.lost      = lost_q;

`ifdef PLL_SUP_LOSS_COUNT_EN
   logic [LOSS_COUNT_W-1:0] loss_count_q, loss_count_d;

   always_comb begin
      loss_count_d = loss_count_q;
      if (loss_entry && loss_count_q != '1) loss_count_d = loss_count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) loss_count_q <= '0;
      else        loss_count_q <= loss_count_d;
   end

   assign bus.loss_count = loss_count_q;
`else
   assign bus.loss_count = '0;
`endif

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release (min 2).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: cycles reset held after stability is reached (min 1).
REQ-003 SHALL have parameter LOSS_FILTER, default 4: consecutive unlocked cycles that count as a lock loss (min 1).
REQ-004 SHALL have ports: clk  in  1  PLL output clock; single clock domain.
REQ-005 SHALL have ports: rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have ports: locked  in  1  raw PLL LOCK, asynchronous to clk.
REQ-007 SHALL have ports: clear_lost  in  1  clears the sticky loss flag.
REQ-008 SHALL have ports: sys_rst_n  out  1  active-low reset to downstream logic.
REQ-009 SHALL have ports: ready  out  1  high only in RUN.
REQ-010 SHALL have ports: lost  out  1  sticky lock-loss flag.
REQ-011 SHALL have ports: loss_count  out  8  saturating count of lock-loss events.

Function
REQ-012 SHALL pass locked through a 2-flop synchronizer (locked_s); every decision uses locked_s only.
REQ-013 SHALL implement states WAIT_LOCK, STABILIZE, HOLD, RUN, LOST, with WAIT_LOCK as the reset state.
REQ-014 WAIT_LOCK: locked_s=1 -> STABILIZE with the counter cleared.
REQ-015 STABILIZE: counter increments per cycle; locked_s=0 -> WAIT_LOCK; counter=STABLE_CYCLES-1 with locked_s=1 -> HOLD with the counter cleared.
REQ-016 HOLD: counter increments; counter=HOLD_CYCLES-1 -> RUN.
REQ-017 HOLD and RUN: a loss filter counts consecutive locked_s=0 cycles and clears on locked_s=1; reaching LOSS_FILTER -> LOST, with priority over the HOLD->RUN transition in the same cycle.
REQ-018 LOST: single-cycle state; lost is set and loss_count increments (saturating at 255) on entry; next state is WAIT_LOCK.
REQ-019 sys_rst_n SHALL be registered and =1 only while in RUN, and 0 in every other state.
REQ-020 ready SHALL equal (state==RUN), registered.
REQ-021 clear_lost=1 SHALL clear lost the next cycle; if a LOST entry occurs in the same cycle, set wins.
REQ-022 A locked glitch shorter than LOSS_FILTER cycles in RUN SHALL NOT change any output.
REQ-023 Counter widths SHALL be $clog2 of the relevant parameter; counters never wrap within a state.

Reset
REQ-024 With rst_n=0 at a clk edge: state=WAIT_LOCK, synchronizer flops=0, all counters=0, sys_rst_n=0, ready=0, lost=0, loss_count=0.
REQ-025 Reset asserted mid-operation (any state) SHALL take effect on the next edge, with the full sequence restarting from WAIT_LOCK.

Configuration
REQ-026 Macro PLL_SUP_LOSS_COUNT_EN: when defined, loss_count SHALL be implemented per REQ-018.
REQ-027 When PLL_SUP_LOSS_COUNT_EN is undefined, loss_count SHALL be tied to 0 with no counter registers, while lost behaviour is unchanged.

Structure
REQ-028 The state enum encoding and default parameter constants SHALL live in the shared package pll_sup_pkg.
REQ-029 The 2-flop synchronizer SHALL be the sub-module sync_2ff, which is reusable.

Verification (STABLE_CYCLES=8, HOLD_CYCLES=4, LOSS_FILTER=2)
REQ-030 Scenario: locked rises at cycle 0 and stays high -> sys_rst_n and ready rise at cycle 2+1+8+4 = 15 (+/-1 per documented registration), with lost=0.
REQ-031 Scenario: locked high 5 cycles, then low, then high -> STABILIZE aborts to WAIT_LOCK; release occurs 15 cycles after the final rise, with loss_count=0.
REQ-032 Scenario: in RUN, locked low for 1 cycle -> no output change; low for 3 cycles -> sys_rst_n=0 and ready=0, lost=1, loss_count=1, then re-release after relock.
REQ-033 Scenario: 256 loss events -> loss_count saturates at 255; with the macro undefined -> loss_count stays 0.
REQ-034 Scenario: clear_lost in the same cycle as a LOST entry -> lost stays 1; clear_lost one cycle later -> lost=0.
REQ-035 Scenario: rst_n pulsed low while in RUN -> all outputs return to reset values next edge, and the full 15-cycle sequence repeats.
